// File: rtl/eth_frame_detector_axi_xbar.sv
// ============================================================================
// eth_frame_detector_axi_xbar
//
// Purpose:
//   AXI4-Lite slave front end for the frame detector family. It accepts one
//   AXI4-Lite access at a time and forwards it to one of C_NUM_PORTS simple
//   req/ack memory windows. The window is chosen from the upper address bits.
//   Window 0 is normally the register file. The other windows are
//   script/FIFO memories.
//
//   Features:
//     - Fair read/write arbitration: when both are pending, the type that
//       was not served last wins.
//     - Per-access timeout, which answers with SLVERR.
//     - DECERR for addresses that fall outside every window.
//     - A saturating 16-bit counter of all error responses.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_axi_aw*/w*/b*     AXI4-Lite write address, write data and write response
//   s_axi_ar*/r*        AXI4-Lite read address and read data
//   mem_req[k]          request to window k, held until ack or timeout
//   mem_addr slice k    word address inside window k
//   mem_we[k]           1 = write access
//   mem_wstrb slice k   byte enables for window k
//   mem_wdata slice k   write data for window k
//   mem_rdata slice k   read data from window k, valid together with ack
//   mem_ack[k]          one-cycle completion pulse from window k
//   err_count           saturating count of SLVERR and DECERR responses
// ============================================================================
module eth_frame_detector_axi_xbar #(
    parameter int C_AXI_WIDTH  = 32,
    parameter int C_ADDR_WIDTH = 16,
    parameter int C_NUM_PORTS  = 3,
    parameter int C_WIN_BITS   = 14,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [C_ADDR_WIDTH-1:0]                s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,

    input  logic [C_AXI_WIDTH-1:0]                 s_axi_wdata,
    input  logic [C_AXI_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,

    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,

    input  logic [C_ADDR_WIDTH-1:0]                s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,

    output logic [C_AXI_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,

    output logic [C_NUM_PORTS-1:0]                 mem_req,
    output logic [C_NUM_PORTS*(C_WIN_BITS-$clog2(C_AXI_WIDTH/8))-1:0] mem_addr,
    output logic [C_NUM_PORTS-1:0]                 mem_we,
    output logic [C_NUM_PORTS*(C_AXI_WIDTH/8)-1:0] mem_wstrb,
    output logic [C_NUM_PORTS*C_AXI_WIDTH-1:0]     mem_wdata,
    input  logic [C_NUM_PORTS*C_AXI_WIDTH-1:0]     mem_rdata,
    input  logic [C_NUM_PORTS-1:0]                 mem_ack,

    output logic [15:0]                            err_count
);

    localparam int STRB_W  = C_AXI_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int MAW     = C_WIN_BITS - BYTE_SH;
    localparam int IDXW    = C_ADDR_WIDTH - C_WIN_BITS;
    localparam int TCW     = $clog2(C_TIMEOUT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCEPT_R = 3'd1;
    localparam logic [2:0] S_ACCEPT_W = 3'd2;
    localparam logic [2:0] S_ACCESS   = 3'd3;
    localparam logic [2:0] S_RESP_R   = 3'd4;
    localparam logic [2:0] S_RESP_W   = 3'd5;

    // ------------------------------------------------------------------
    // State and transaction registers
    // ------------------------------------------------------------------
    logic [2:0]             r_state;
    logic                   r_lastWrite;
    logic                   r_isWrite;
    logic [C_NUM_PORTS-1:0] r_memReq;
    logic [MAW-1:0]         r_wordAddr;
    logic [C_AXI_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [TCW-1:0]         r_tcount;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [C_AXI_WIDTH-1:0] r_rdata;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic [15:0]            r_errCount;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_rdPend;
    logic                    w_wrPend;
    logic                    w_pickRead;
    logic [C_ADDR_WIDTH-1:0] w_acceptAddr;
    logic [IDXW-1:0]         w_idx;
    logic [31:0]             w_idxExt;
    logic [C_NUM_PORTS-1:0]  w_sel;
    logic                    w_hit;
    logic                    w_ackHit;
    logic [C_AXI_WIDTH-1:0]  w_ackData;
    logic                    w_timeout;
    logic                    w_rHandshake;
    logic                    w_bHandshake;
    logic                    w_errInc;
    logic                    w_unusedBits;

    // The protection bits carry no meaning for these windows. The byte-lane
    // bits of the addresses are also unused, because accesses are word-wide
    // and the strobes select the bytes.
    assign w_unusedBits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    // A write is only pending when both AW and W are present. The two halves
    // of a write are never taken separately.
    assign w_rdPend   = s_axi_arvalid;
    assign w_wrPend   = s_axi_awvalid & s_axi_wvalid;
    assign w_pickRead = w_rdPend & (~w_wrPend | r_lastWrite);

    // The address being accepted this cycle comes from whichever channel the
    // accept state belongs to.
    assign w_acceptAddr = (r_state == S_ACCEPT_W) ? s_axi_awaddr : s_axi_araddr;
    assign w_idx        = w_acceptAddr[C_ADDR_WIDTH-1:C_WIN_BITS];
    assign w_idxExt     = 32'(w_idx);

    // One-hot window select. An out-of-range index leaves it all zero, which
    // is also how an unmapped address is detected.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < C_NUM_PORTS; k++) begin
            if (w_idxExt == 32'(k)) begin
                w_sel[k] = 1'b1;
            end
        end
    end

    assign w_hit = |w_sel;

    // An ack only counts on a port whose request is currently high. This
    // makes stray acks and late acks after a timeout harmless.
    assign w_ackHit = |(mem_ack & r_memReq);

    // The request vector is one-hot, so ORing the masked slices gives the
    // data of the active port.
    always_comb begin
        w_ackData = '0;
        for (int k = 0; k < C_NUM_PORTS; k++) begin
            if (r_memReq[k]) begin
                w_ackData = w_ackData | mem_rdata[k*C_AXI_WIDTH +: C_AXI_WIDTH];
            end
        end
    end

    assign w_timeout    = (r_tcount == TCW'(C_TIMEOUT - 1));
    assign w_rHandshake = r_rvalid & s_axi_rready;
    assign w_bHandshake = r_bvalid & s_axi_bready;
    assign w_errInc     = (w_rHandshake & r_rresp[1]) | (w_bHandshake & r_bresp[1]);

    // ------------------------------------------------------------------
    // Main transaction FSM. Only one access is in flight at a time. The
    // IDLE state makes the arbitration decision. The accept state raises
    // the ready signals and captures the request. ACCESS waits for the ack
    // or the timeout. The response states hold valid until the master
    // takes the response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lastWrite <= 1'b1;
            r_isWrite   <= 1'b0;
            r_memReq    <= '0;
            r_wordAddr  <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_tcount    <= '0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pickRead) begin
                        r_state     <= S_ACCEPT_R;
                        r_lastWrite <= 1'b0;
                    end else if (w_wrPend) begin
                        r_state     <= S_ACCEPT_W;
                        r_lastWrite <= 1'b1;
                    end
                end

                S_ACCEPT_R, S_ACCEPT_W: begin
                    r_isWrite  <= (r_state == S_ACCEPT_W);
                    r_wordAddr <= w_acceptAddr[C_WIN_BITS-1:BYTE_SH];
                    r_wdata    <= s_axi_wdata;
                    r_wstrb    <= s_axi_wstrb;
                    r_tcount   <= '0;
                    if (w_hit) begin
                        r_memReq <= w_sel;
                        r_state  <= S_ACCESS;
                    end else if (r_state == S_ACCEPT_W) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_DECERR;
                        r_state  <= S_RESP_W;
                    end else begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_DECERR;
                        r_rdata  <= '0;
                        r_state  <= S_RESP_R;
                    end
                end

                // An ack is checked before the timeout, so an ack that
                // arrives in the timeout cycle still completes with OKAY.
                S_ACCESS: begin
                    if (w_ackHit || w_timeout) begin
                        r_memReq <= '0;
                        if (r_isWrite) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_ackHit ? RESP_OKAY : RESP_SLVERR;
                            r_state  <= S_RESP_W;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_ackHit ? RESP_OKAY : RESP_SLVERR;
                            r_rdata  <= w_ackHit ? w_ackData : '0;
                            r_state  <= S_RESP_R;
                        end
                    end else begin
                        r_tcount <= r_tcount + 1'b1;
                    end
                end

                S_RESP_R: begin
                    if (w_rHandshake) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                S_RESP_W: begin
                    if (w_bHandshake) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_memReq <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error counter. It counts a response when the master takes it, not
    // when the response is produced. It sticks at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errCount <= '0;
        end else if (w_errInc && (r_errCount != 16'hFFFF)) begin
            r_errCount <= r_errCount + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side outputs. A port's slice carries the captured request
    // only while that port's req is high. Every other slice is held at
    // zero. Write data and strobes are also zero during reads.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_we    = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        for (int k = 0; k < C_NUM_PORTS; k++) begin
            if (r_memReq[k]) begin
                mem_addr[k*MAW +: MAW] = r_wordAddr;
                mem_we[k]              = r_isWrite;
                if (r_isWrite) begin
                    mem_wstrb[k*STRB_W +: STRB_W]           = r_wstrb;
                    mem_wdata[k*C_AXI_WIDTH +: C_AXI_WIDTH] = r_wdata;
                end
            end
        end
    end

    assign mem_req = r_memReq;

    // The ready signals are decoded straight from the state. Each accept
    // state lasts exactly one cycle, so ready pulses for a single cycle.
    assign s_axi_arready = (r_state == S_ACCEPT_R);
    assign s_axi_awready = (r_state == S_ACCEPT_W);
    assign s_axi_wready  = (r_state == S_ACCEPT_W);

    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign err_count    = r_errCount;

endmodule

// File: tb/tb_eth_frame_detector_axi_xbar.sv
// ============================================================================
// tb_eth_frame_detector_axi_xbar
//
// Purpose:
//   Directed testbench for eth_frame_detector_axi_xbar. It uses three
//   windows of 16 KiB, 32-bit data, and a short timeout of 16 cycles.
//   Each scenario task drives the AXI master and the memory side by hand
//   and checks the outputs about 1 ns after each rising clock edge.
// ============================================================================
module tb_eth_frame_detector_axi_xbar;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int NP  = 3;
    localparam int WB  = 14;
    localparam int TO  = 16;
    localparam int SW  = DW / 8;
    localparam int MAW = WB - 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [AW-1:0]       s_axi_awaddr;
    logic [2:0]          s_axi_awprot;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DW-1:0]       s_axi_wdata;
    logic [SW-1:0]       s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [AW-1:0]       s_axi_araddr;
    logic [2:0]          s_axi_arprot;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DW-1:0]       s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [NP-1:0]       mem_req;
    logic [NP*MAW-1:0]   mem_addr;
    logic [NP-1:0]       mem_we;
    logic [NP*SW-1:0]    mem_wstrb;
    logic [NP*DW-1:0]    mem_wdata;
    logic [NP*DW-1:0]    mem_rdata;
    logic [NP-1:0]       mem_ack;
    logic [15:0]         err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eth_frame_detector_axi_xbar #(
        .C_AXI_WIDTH (DW),
        .C_ADDR_WIDTH(AW),
        .C_NUM_PORTS (NP),
        .C_WIN_BITS  (WB),
        .C_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .err_count    (err_count)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset holds every output at zero.
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake got %b want 00000",
                     {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
        end
        checks++;
        if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_resp got bresp=%b rresp=%b rdata=%h want 0",
                     s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        checks++;
        if ({mem_req, mem_we, mem_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem got req=%b we=%b addr=%h want 0", mem_req, mem_we, mem_addr);
        end
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_errcount got %h want 0000", err_count);
        end
        rst = 1'b0;
        tick();
    endtask

    // Single write to 0x4008 on window 1, which acks two cycles after req.
    task automatic test_single_write();
        int n;
        s_axi_awaddr  = 16'h4008;
        s_axi_wdata   = 32'hDEADBEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b0;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!(s_axi_awready && s_axi_wready)) begin
            errors++;
            $display("[TB] FAIL wr1_accept got awready=%b wready=%b want 1 1", s_axi_awready, s_axi_wready);
        end
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checks++;
        if ({mem_req, mem_we} !== 6'b010_010) begin
            errors++;
            $display("[TB] FAIL wr1_req got req=%b we=%b want 010 010", mem_req, mem_we);
        end
        checks++;
        if (mem_addr[2*MAW-1:MAW] !== 12'd2 || {mem_addr[3*MAW-1:2*MAW], mem_addr[MAW-1:0]} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL wr1_addr got %h want slice1=002 others 0", mem_addr);
        end
        checks++;
        if (mem_wdata[2*DW-1:DW] !== 32'hDEADBEEF || mem_wstrb[2*SW-1:SW] !== 4'hF) begin
            errors++;
            $display("[TB] FAIL wr1_data got wdata=%h wstrb=%h want DEADBEEF F",
                     mem_wdata[2*DW-1:DW], mem_wstrb[2*SW-1:SW]);
        end
        tick();
        mem_ack = 3'b010;
        checks++;
        if ({mem_req, s_axi_bvalid} !== 4'b010_0) begin
            errors++;
            $display("[TB] FAIL wr1_wait got req=%b bvalid=%b want 010 0", mem_req, s_axi_bvalid);
        end
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({s_axi_bvalid, s_axi_bresp, mem_req} !== 6'b1_00_000) begin
            errors++;
            $display("[TB] FAIL wr1_bresp got bvalid=%b bresp=%b req=%b want 1 00 000",
                     s_axi_bvalid, s_axi_bresp, mem_req);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr1_bdone got bvalid=%b want 0", s_axi_bvalid);
        end
    endtask

    // A read and a write are both pending the whole time. Service must
    // alternate R, W, R, W, because the last-served marker resets to write.
    task automatic test_back_to_back();
        byte order[4];
        int  nOrd = 0;
        int  nRd  = 0;
        int  nWr  = 0;
        int  cyc  = 0;
        bit  arHs;
        bit  awHs;
        byte want;
        order[0] = "-"; order[1] = "-"; order[2] = "-"; order[3] = "-";
        s_axi_araddr  = 16'h0000;
        s_axi_awaddr  = 16'h0004;
        s_axi_wdata   = 32'h01020304;
        s_axi_wstrb   = 4'hF;
        s_axi_arvalid = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_rready  = 1'b1;
        s_axi_bready  = 1'b1;
        while (nOrd < 4 && cyc < 80) begin
            arHs = s_axi_arvalid && s_axi_arready;
            awHs = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
            tick();
            cyc++;
            mem_ack = mem_req;
            if (arHs && nOrd < 4) begin
                order[nOrd] = "R";
                nOrd++;
                nRd++;
                if (nRd == 2) s_axi_arvalid = 1'b0;
            end
            if (awHs && nOrd < 4) begin
                order[nOrd] = "W";
                nOrd++;
                nWr++;
                if (nWr == 2) begin
                    s_axi_awvalid = 1'b0;
                    s_axi_wvalid  = 1'b0;
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            mem_ack = mem_req;
        end
        mem_ack       = 3'b000;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_bready  = 1'b0;
        checks++;
        if (nOrd != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d accepts want 4", nOrd);
        end
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? "R" : "W";
            checks++;
            if (order[i] !== want) begin
                errors++;
                $display("[TB] FAIL b2b_order[%0d] got %c want %c", i, order[i], want);
            end
        end
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid, mem_req} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got rvalid=%b bvalid=%b req=%b want 0",
                     s_axi_rvalid, s_axi_bvalid, mem_req);
        end
    endtask

    // Read from 0x4004. Window 1 never acks, so the request must time out
    // after 16 cycles with SLVERR. A late ack must then have no effect.
    task automatic test_timeout();
        int n;
        int reqCycles;
        mem_rdata[2*DW-1:DW] = 32'h12345678;
        s_axi_araddr  = 16'h4004;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        n = 0;
        while (!s_axi_arready && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_accept got arready=%b want 1", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
        checks++;
        if (mem_addr[2*MAW-1:MAW] !== 12'd1 || mem_we !== 3'b000) begin
            errors++;
            $display("[TB] FAIL to_addr got addr1=%h we=%b want 001 000", mem_addr[2*MAW-1:MAW], mem_we);
        end
        reqCycles = 0;
        while (mem_req[1] && reqCycles < 40) begin
            reqCycles++;
            tick();
        end
        checks++;
        if (reqCycles != TO) begin
            errors++;
            $display("[TB] FAIL to_reqlen got %0d cycles want %0d", reqCycles, TO);
        end
        checks++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL to_resp got rvalid=%b rresp=%b rdata=%h want 1 10 0",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL to_err_before got %0d want 0", err_count);
        end
        tick(); tick(); tick();
        mem_ack = 3'b010;
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata, mem_req} !== {1'b1, 2'b10, 32'h0, 3'b000}) begin
            errors++;
            $display("[TB] FAIL to_late_ack got rvalid=%b rresp=%b rdata=%h req=%b want 1 10 0 000",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata, mem_req);
        end
        s_axi_rready = 1'b1;
        tick();
        checks++;
        if ({s_axi_rvalid, err_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("[TB] FAIL to_done got rvalid=%b err=%0d want 0 1", s_axi_rvalid, err_count);
        end
        tick(); tick(); tick();
        s_axi_rready = 1'b0;
        checks++;
        if ({s_axi_rvalid, s_axi_arready, mem_req} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL to_quiet got rvalid=%b arready=%b req=%b want 0",
                     s_axi_rvalid, s_axi_arready, mem_req);
        end
        mem_rdata = '0;
    endtask

    // Read from 0xC000. The index is 3, which is outside the three windows,
    // so the response must be DECERR with no memory request at all.
    task automatic test_decerr();
        int n;
        bit reqSeen = 1'b0;
        s_axi_araddr  = 16'hC000;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        n = 0;
        while (!s_axi_arready && n < 10) begin
            if (mem_req != 3'b000) reqSeen = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dec_accept got arready=%b want 1", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
        if (mem_req != 3'b000) reqSeen = 1'b1;
        checks++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b11, 32'h0}) begin
            errors++;
            $display("[TB] FAIL dec_resp got rvalid=%b rresp=%b rdata=%h want 1 11 0",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        tick();
        if (mem_req != 3'b000) reqSeen = 1'b1;
        s_axi_rready = 1'b0;
        checks++;
        if ({s_axi_rvalid, err_count} !== {1'b0, 16'd2}) begin
            errors++;
            $display("[TB] FAIL dec_done got rvalid=%b err=%0d want 0 2", s_axi_rvalid, err_count);
        end
        checks++;
        if (reqSeen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dec_noreq got reqSeen=%b want 0", reqSeen);
        end
    endtask

    // rready is held low for 10 cycles. The response must stay stable, and
    // a second read must wait until the first response has been taken.
    task automatic test_backpressure();
        int n;
        mem_rdata[DW-1:0] = 32'hA5A55A5A;
        s_axi_araddr  = 16'h0010;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        n = 0;
        while (!s_axi_arready && n < 10) begin
            tick();
            n++;
        end
        tick();
        s_axi_arvalid = 1'b0;
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        mem_rdata[DW-1:0] = 32'h0BADF00D;
        s_axi_araddr  = 16'h0014;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata} !== {1'b1, 1'b0, 2'b00, 32'hA5A55A5A}) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got rvalid=%b arready=%b rresp=%b rdata=%h want 1 0 00 A5A55A5A",
                         i, s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata);
            end
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release got rvalid=%b want 0", s_axi_rvalid);
        end
        n = 0;
        while (!s_axi_arready && n < 6) begin
            tick();
            n++;
        end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second_accept got arready=%b want 1", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h0BADF00D}) begin
            errors++;
            $display("[TB] FAIL bp_second_data got rvalid=%b rresp=%b rdata=%h want 1 00 0BADF00D",
                     s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        mem_rdata = '0;
    endtask

    // Reset is asserted while window 2 has a request outstanding. The
    // transaction must vanish without a response, and a later write must
    // complete normally.
    task automatic test_reset_mid();
        int n;
        bit bSeen = 1'b0;
        s_axi_awaddr  = 16'h8000;
        s_axi_wdata   = 32'h11111111;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 10) begin
            tick();
            n++;
        end
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checks++;
        if (mem_req !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rm_req got %b want 100", mem_req);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_rvalid, err_count} !== 23'h0) begin
            errors++;
            $display("[TB] FAIL rm_after got req=%b bvalid=%b awready=%b err=%0d want 0",
                     mem_req, s_axi_bvalid, s_axi_awready, err_count);
        end
        for (int i = 0; i < 5; i++) begin
            if (s_axi_bvalid || mem_req != 3'b000) bSeen = 1'b1;
            tick();
        end
        checks++;
        if (bSeen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rm_no_resp got activity=%b want 0", bSeen);
        end
        s_axi_awaddr  = 16'h0020;
        s_axi_wdata   = 32'hCAFEF00D;
        s_axi_wstrb   = 4'h3;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 10) begin
            tick();
            n++;
        end
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checks++;
        if ({mem_req, mem_addr[MAW-1:0], mem_wstrb[SW-1:0], mem_wdata[DW-1:0]} !==
            {3'b001, 12'd8, 4'h3, 32'hCAFEF00D}) begin
            errors++;
            $display("[TB] FAIL rm_wr_mem got req=%b addr0=%h wstrb0=%h wdata0=%h want 001 008 3 CAFEF00D",
                     mem_req, mem_addr[MAW-1:0], mem_wstrb[SW-1:0], mem_wdata[DW-1:0]);
        end
        mem_ack = 3'b001;
        tick();
        mem_ack = 3'b000;
        checks++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b1_00) begin
            errors++;
            $display("[TB] FAIL rm_wr_bresp got bvalid=%b bresp=%b want 1 00", s_axi_bvalid, s_axi_bresp);
        end
        tick();
        s_axi_bready = 1'b0;
        checks++;
        if ({s_axi_bvalid, err_count} !== {1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL rm_wr_done got bvalid=%b err=%0d want 0 0", s_axi_bvalid, err_count);
        end
    endtask

    initial begin
        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = 3'b000;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = 3'b000;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        mem_rdata     = '0;
        mem_ack       = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_timeout();
        test_decerr();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
